// File: rtl/layer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_ctrl_pkg
// Brief    : Shared state encoding and sizing helper for layer_stream_sequencer
// Revision : 1.0 - initial release
// ============================================================================
package layer_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Word-index counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : layer_ctrl_pkg
`default_nettype wire

// File: rtl/layer_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_stream_sequencer
// Brief    : Captures a parallel layer output frame and replays it as a serial
//            valid/ready word stream with overflow and partial-valid flags.
// Revision : 1.0 - initial release
// ============================================================================
module layer_stream_sequencer
    import layer_ctrl_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           layer_valid,
    input  logic [NN*dataWidth-1:0] layer_data,
    input  logic                    out_ready,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    err_overflow,
    output logic                    err_partial
);

    localparam int            CW         = cnt_width(NN);
    localparam logic [CW-1:0] c_last_idx = CW'(NN - 1);

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [dataWidth-1:0] r_buf [NN];
    logic                 r_x_valid;
    logic [dataWidth-1:0] r_x_in;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_err_overflow;
    logic                 r_err_partial;

    logic [dataWidth-1:0] w_words [NN];
    logic                 w_capture;
    logic                 w_partial;
    logic                 w_xfer;
    logic [CW-1:0]        w_cnt_nxt;

    for (genvar k = 0; k < NN; k++) begin : g_words
        assign w_words[k] = layer_data[k*dataWidth +: dataWidth];
    end

    assign w_capture = &layer_valid;
    assign w_partial = (|layer_valid) && !w_capture;
    assign w_xfer    = r_x_valid && out_ready;
    assign w_cnt_nxt = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_x_valid      <= 1'b0;
            r_x_in         <= '0;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_partial  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_partial) begin
                r_err_partial <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_buf     <= w_words;
                        r_cnt     <= '0;
                        r_x_in    <= w_words[0];
                        r_x_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (w_xfer && (r_cnt == c_last_idx)) begin
                        r_frame_done <= 1'b1;
                        r_cnt        <= '0;
                        // A capture landing on the final transfer chains the next frame without a bubble.
                        if (w_capture) begin
                            r_buf  <= w_words;
                            r_x_in <= w_words[0];
                        end else begin
                            r_x_valid <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end else begin
                        if (w_xfer) begin
                            r_cnt  <= w_cnt_nxt;
                            r_x_in <= r_buf[w_cnt_nxt];
                        end
                        if (w_capture) begin
                            r_err_overflow <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x_valid      = r_x_valid;
    assign x_in         = r_x_in;
    assign busy         = r_busy;
    assign frame_done   = r_frame_done;
    assign err_overflow = r_err_overflow;
    assign err_partial  = r_err_partial;

endmodule : layer_stream_sequencer
`default_nettype wire

// File: tb/tb_layer_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_stream_sequencer
// Brief    : Scoreboard bench for layer_stream_sequencer (NN=10, 16-bit words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_stream_sequencer;

    localparam int NN = 10;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NN-1:0]     layer_valid = '0;
    logic [NN*DW-1:0]  layer_data = '0;
    logic              out_ready = 1'b1;
    logic              x_valid;
    logic [DW-1:0]     x_in;
    logic              busy;
    logic              frame_done;
    logic              err_overflow;
    logic              err_partial;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          xfer_cnt = 0;
    logic [DW-1:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_x = '0;

    layer_stream_sequencer #(.NN(NN), .dataWidth(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .layer_valid  (layer_valid),
        .layer_data   (layer_data),
        .out_ready    (out_ready),
        .x_valid      (x_valid),
        .x_in         (x_in),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_overflow (err_overflow),
        .err_partial  (err_partial)
    );

    always #5 clk = ~clk;

    // Monitor: pops the scoreboard on every accepted word, checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && x_valid) begin
                total++;
                if (x_in !== prev_x) begin
                    bad++;
                    $display("FAIL stall_hold: x_in=%h required=%h", x_in, prev_x);
                end
            end
            if (x_valid && out_ready) begin
                xfer_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word: x_in=%h required=none", x_in);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (x_in !== e) begin
                        bad++;
                        $display("FAIL word: x_in=%h required=%h", x_in, e);
                    end
                end
            end
            if (frame_done === 1'b1) done_cnt++;
            prev_stall = x_valid && !out_ready;
            prev_x     = x_in;
        end
    end

    // Called at posedge+1; the frame is sampled on the following posedge.
    task automatic load_frame(input logic [DW-1:0] base, input bit expect_it);
        for (int k = 0; k < NN; k++) begin
            layer_data[k*DW +: DW] = base + DW'(k);
            if (expect_it) exp_q.push_back(base + DW'(k));
        end
        layer_valid = '1;
        @(posedge clk); #1;
        layer_valid = '0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            if (!busy && exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        total++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b pending=%0d required busy=0 pending=0", name, busy, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({x_valid, x_in, busy, frame_done, err_overflow, err_partial} !== '0) begin
            bad++;
            $display("FAIL reset_state: xv=%b xin=%h busy=%b done=%b ov=%b pa=%b required all 0",
                     x_valid, x_in, busy, frame_done, err_overflow, err_partial);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        int n = 0;
        int d0 = done_cnt;
        out_ready = 1'b1;
        load_frame(16'h0100, 1'b1);
        @(negedge clk);
        total++;
        if (x_valid !== 1'b1 || x_in !== 16'h0100) begin
            bad++;
            $display("FAIL basic_latency: xv=%b xin=%h required xv=1 xin=0100", x_valid, x_in);
        end
        while (x_valid === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (n != NN) begin
            bad++;
            $display("FAIL basic_run_len: got=%0d required=%0d", n, NN);
        end
        total++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b busy=%b required done=1 busy=0", frame_done, busy);
        end
        @(posedge clk); #1;
        wait_idle("basic");
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL basic_done_count: got=%0d required=1", done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int x0 = xfer_cnt;
        int d0 = done_cnt;
        int i = 0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        load_frame(16'h0100, 1'b1);
        while ((busy || exp_q.size() != 0) && i < 100) begin
            out_ready = pat[i % 4];
            i++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle("bp");
        total++;
        if (xfer_cnt - x0 != NN || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL bp_counts: xfers=%0d dones=%0d required %0d and 1", xfer_cnt - x0, done_cnt - d0, NN);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        out_ready = 1'b1;
        load_frame(16'h0100, 1'b1);
        repeat (NN - 1) @(posedge clk);
        #1;
        load_frame(16'h0200, 1'b1);
        @(negedge clk);
        total++;
        if (x_valid !== 1'b1 || x_in !== 16'h0200 || frame_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_seam: xv=%b xin=%h done=%b required xv=1 xin=0200 done=1", x_valid, x_in, frame_done);
        end
        @(posedge clk); #1;
        wait_idle("b2b");
        total++;
        if (err_overflow !== 1'b0 || done_cnt - d0 != 2) begin
            bad++;
            $display("FAIL b2b_flags: ov=%b dones=%0d required ov=0 dones=2", err_overflow, done_cnt - d0);
        end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        load_frame(16'h0100, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        load_frame(16'h0300, 1'b0);
        @(negedge clk);
        total++;
        if (err_overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_flag: ov=%b required=1", err_overflow);
        end
        @(posedge clk); #1;
        wait_idle("ovf");
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++;
        if (err_overflow !== 1'b1 || x_valid !== 1'b0) begin
            bad++;
            $display("FAIL ovf_sticky: ov=%b xv=%b required ov=1 xv=0", err_overflow, x_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_partial();
        do_reset();
        layer_valid = 10'h3FE;
        @(posedge clk); #1;
        layer_valid = '0;
        @(negedge clk);
        total++;
        if (err_partial !== 1'b1 || x_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL partial: pa=%b xv=%b busy=%b required pa=1 xv=0 busy=0", err_partial, x_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        int d0 = done_cnt;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(16'h0400 + DW'(k));
        load_frame(16'h0400, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({x_valid, busy, frame_done, err_overflow, err_partial} !== 5'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL rst_mid: xv=%b busy=%b done=%b ov=%b pa=%b pending=%0d required all 0",
                     x_valid, busy, frame_done, err_overflow, err_partial, exp_q.size());
        end
        exp_q.delete();
        @(posedge clk); #1;
        load_frame(16'h0500, 1'b1);
        wait_idle("rst_mid");
        total++;
        if (done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL rst_mid_dones: got=%0d required=1", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_partial();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_layer_stream_sequencer
`default_nettype wire

// File: doc/layer_stream_sequencer.md
Name: layer_stream_sequencer

Overview:
- Sits between two fully connected layers.
- Captures the NN parallel neuron outputs of one layer when that layer signals completion.
- Replays them one word per transfer as the serial x_in / x_valid stream that the next layer's neurons consume.
- Provides backpressure, back-to-back frame acceptance, done pulse and sticky error flags for the top-level controller.

Parameters:
- NN, 10, number of neurons in the producing layer (words per frame); NN >= 2
- dataWidth, 16, width of one neuron output word

Ports:
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- layer_valid  input  NN  per-neuron output valid from producing layer (its o_valid)
- layer_data  input  NN*dataWidth  packed neuron outputs; word k at [k*dataWidth +: dataWidth]
- out_ready  input  1  next layer/consumer accepts the current word this cycle
- x_valid  output  1  serial word valid toward next layer
- x_in  output  dataWidth  serial word toward next layer
- busy  output  1  high while a frame is held or being sent
- frame_done  output  1  one-cycle pulse after the last word of a frame transfers
- err_overflow  output  1  sticky: a frame arrived while busy and was dropped
- err_partial  output  1  sticky: layer_valid was neither all-zero nor all-one in some cycle

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state=IDLE, cnt=0, x_valid=0, x_in=0, busy=0, frame_done=0, err_overflow=0, err_partial=0. Buffer contents are don't-care.
- Reset mid-frame aborts the frame:
  - no further x_valid
  - no frame_done
  - error flags cleared
- States: IDLE, SEND.
- Capture condition: layer_valid == all-ones.
  - Capture loads buffer <= layer_data and sets cnt <= 0.
- IDLE:
  - On capture, go to SEND next cycle.
  - x_valid, busy and x_in are driven from registers only. Word 0 appears the cycle after capture (latency 1).
- SEND:
  - x_valid=1, busy=1, x_in = buffer word[cnt].
  - Transfer = x_valid && out_ready.
  - Transfer with cnt < NN-1: cnt++.
  - Transfer with cnt == NN-1: frame ends.
    - frame_done pulses in the following cycle.
    - If no capture in the same cycle: go to IDLE, cnt <= 0.
    - If capture in the same cycle: reload buffer, cnt <= 0, stay in SEND. Word 0 of the new frame follows with no bubble. This is not an overflow.
  - out_ready low holds x_in and cnt stable. x_valid stays high until the word transfers.
  - Capture in SEND other than on the final transfer: frame dropped, buffer unchanged, err_overflow <= 1.
- err_partial <= 1 in any cycle where layer_valid != 0 and != all-ones. A partial vector never captures.
- Error flags clear only on rst.
- Counter: width $clog2(NN). Never exceeds NN-1; no wrap beyond.
- Words are sent in index order 0..NN-1, unmodified, full dataWidth. No arithmetic on data.
- out_ready is ignored in IDLE.

Decomposition:
- Package layer_ctrl_pkg:
  - state enum (IDLE, SEND)
  - localparam function for counter width, clog2 with minimum 1
- Single module. The word-select mux is inline; no sub-module is warranted.

Test Plan:
- Basic frame: NN=10, layer_data words = 0x0100+k, out_ready=1, layer_valid=all-ones for 1 cycle → x_valid high for exactly 10 consecutive cycles starting 1 cycle after capture, x_in = 0x0100..0x0109 in order; frame_done pulses 1 cycle after word 9; busy then 0.
- Backpressure: same frame, out_ready toggles 1,0,0,1,... → each word held stable while out_ready=0; exactly 10 transfers total, order preserved, no duplicates.
- Back-to-back: second frame (0x0200+k) captured in the same cycle as word 9 of the first frame transfers → 0x0200 appears next cycle, no idle gap, err_overflow stays 0, frame_done pulses once per frame (2 total).
- Overflow: second capture at word 4 of the first frame → first frame completes unaltered (0x0100..0x0109), second frame never emitted, err_overflow=1 and stays 1 until rst.
- Partial valid: layer_valid=0x3FE for 1 cycle → no capture, x_valid stays 0, err_partial=1.
- Reset mid-frame: rst asserted for 1 cycle after word 3 → next cycle x_valid=0, busy=0, no frame_done, flags 0. A following full capture streams correctly from word 0.
